// File: rtl/ok_register_bank.sv
// ok_register_bank
//   Memory-mapped register bank behind a register bridge. It decodes an
//   absolute address relative to BASE_ADDR and provides these registers:
//     0x00..NUM_CTRL-1  CTRL[n]   read/write, drives ctrl_out slice n
//     0x20              STATUS    read-only, live status_in
//     0x21              EVENT     sticky rising-edge flags, write-1-to-clear
//     0x22              IRQ_MASK  read/write
//     0x23              VERSION   read-only constant
//     0x24              WR_CNT    read-only count of accepted writes
//     0x25              ERR_CNT   read-only, saturating; present only when
//                                 OKREGBANK_ERRCNT_EN is defined
//
// Access protocol: ep_read and ep_write are strobes with no backpressure.
// Each cycle in which a strobe is high is one complete access. Write data
// (ep_dataout) is valid only in the cycle where ep_write is high. Read data
// appears on ep_datain one cycle after the ep_read cycle. It then holds
// until the next read.
//
// Ports:
//   okClk       clock (rising edge)
//   rst_n       asynchronous active-low reset
//   ep_address  absolute register address
//   ep_write    write strobe
//   ep_dataout  write data
//   ep_read     read strobe
//   ep_datain   registered read data
//   ctrl_out    CTRL registers concatenated, CTRL[0] in bits [31:0]
//   status_in   live user status
//   event_in    user event levels
//   irq         registered |(EVENT & IRQ_MASK)
module ok_register_bank #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_CTRL  = 8,
  parameter logic [31:0] VERSION   = 32'h0001_0000
) (
  input  logic                     okClk,
  input  logic                     rst_n,
  input  logic [31:0]              ep_address,
  input  logic                     ep_write,
  input  logic [31:0]              ep_dataout,
  input  logic                     ep_read,
  output logic [31:0]              ep_datain,
  output logic [NUM_CTRL*32-1:0]   ctrl_out,
  input  logic [31:0]              status_in,
  input  logic [31:0]              event_in,
  output logic                     irq
);

  localparam logic [31:0] OFF_STATUS  = 32'h20;
  localparam logic [31:0] OFF_EVENT   = 32'h21;
  localparam logic [31:0] OFF_MASK    = 32'h22;
  localparam logic [31:0] OFF_VERSION = 32'h23;
  localparam logic [31:0] OFF_WRCNT   = 32'h24;

  logic [31:0] ctrl_q [NUM_CTRL];
  logic [31:0] event_r;
  logic [31:0] mask_r;
  logic [31:0] wr_cnt;
  logic [31:0] event_q;
  // Cleared by reset so the first cycle after release only captures
  // event_in; levels already high at release are not treated as edges.
  logic        armed;

  logic [31:0] offset;
  logic        is_ctrl;
  logic        is_event;
  logic        is_mask;
  logic        wr_ok;
  logic [31:0] rise;
  logic [31:0] rdata;

  // Subtraction wraps, so addresses below BASE_ADDR land on huge offsets.
  assign offset   = ep_address - BASE_ADDR;
  assign is_ctrl  = offset < 32'(NUM_CTRL);
  assign is_event = offset == OFF_EVENT;
  assign is_mask  = offset == OFF_MASK;
  assign wr_ok    = ep_write && (is_ctrl || is_event || is_mask);
  assign rise     = armed ? (event_in & ~event_q) : 32'h0;

`ifdef OKREGBANK_ERRCNT_EN
  localparam logic [31:0] OFF_ERRCNT = 32'h25;
  logic [31:0] err_cnt;
  logic        is_ro;
  logic        is_mapped;
  logic        err_hit;

  assign is_ro     = (offset == OFF_STATUS) || (offset == OFF_VERSION) ||
                     (offset == OFF_WRCNT)  || (offset == OFF_ERRCNT);
  assign is_mapped = is_ctrl || is_event || is_mask || is_ro;
  // One increment per cycle, even when both strobes hit a bad address.
  assign err_hit   = ((ep_read || ep_write) && !is_mapped) || (ep_write && is_ro);

  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 32'h0;
    end else if (err_hit && (err_cnt != 32'hFFFF_FFFF)) begin
      err_cnt <= err_cnt + 32'h1;
    end
  end
`endif

  // Read mux sees pre-write state, so a same-cycle read and write of one
  // offset returns the old value.
  always_comb begin
    rdata = 32'h0;
    for (int n = 0; n < NUM_CTRL; n++) begin
      if (offset == 32'(n)) rdata = ctrl_q[n];
    end
    case (offset)
      OFF_STATUS:  rdata = status_in;
      OFF_EVENT:   rdata = event_r;
      OFF_MASK:    rdata = mask_r;
      OFF_VERSION: rdata = VERSION;
      OFF_WRCNT:   rdata = wr_cnt;
`ifdef OKREGBANK_ERRCNT_EN
      OFF_ERRCNT:  rdata = err_cnt;
`endif
      default: ;
    endcase
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
    always_ff @(posedge okClk or negedge rst_n) begin
      if (!rst_n) begin
        ctrl_q[g] <= 32'h0;
      end else if (ep_write && (offset == 32'(g))) begin
        ctrl_q[g] <= ep_dataout;
      end
    end
    assign ctrl_out[g*32 +: 32] = ctrl_q[g];
  end

  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      event_r   <= 32'h0;
      mask_r    <= 32'h0;
      wr_cnt    <= 32'h0;
      event_q   <= 32'h0;
      armed     <= 1'b0;
      ep_datain <= 32'h0;
      irq       <= 1'b0;
    end else begin
      event_q <= event_in;
      armed   <= 1'b1;
      // New edges are ORed in after the clear, so a set beats a clear.
      if (ep_write && is_event) begin
        event_r <= (event_r & ~ep_dataout) | rise;
      end else begin
        event_r <= event_r | rise;
      end
      if (ep_write && is_mask) mask_r <= ep_dataout;
      if (wr_ok) wr_cnt <= wr_cnt + 32'h1;
      if (ep_read) ep_datain <= rdata;
      irq <= |(event_r & mask_r);
    end
  end

endmodule
